// File: rtl/fetch_unit_pkg.sv
// +----------------------------------------------------------------------+
// | fetch_unit_pkg                                                       |
// | Shared fetch-stage constants and state encoding.                     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package fetch_unit_pkg;

    // addi x0,x0,0
    localparam logic [31:0] c_NOP_INSTR   = 32'h0000_0013;
    localparam int          c_FETCH_TMR_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_unit.sv
// +----------------------------------------------------------------------+
// | fetch_unit                                                           |
// | Instruction fetch: one bus read per PC, delivered to decode via o_EN.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR      = c_NOP_INSTR,
    parameter int          TIMEOUT_CYCLES = 255
)(
    input  logic        i_CLK,
    input  logic        i_RSTn,
    input  logic [31:0] i_PC,
    input  logic        i_STALL,
    input  logic        i_FLUSH,
    output logic        o_INSTR_REQ,
    output logic [31:0] o_INSTR_ADDR,
    input  logic        i_INSTR_ACK,
    input  logic [31:0] i_INSTR_DATA,
    output logic [31:0] o_INSTRUCTION,
    output logic        o_EN,
    output logic        o_MISALIGNED,
    output logic        o_BUS_ERR,
    output logic        o_BUSY
);

    localparam logic [c_FETCH_TMR_W-1:0] c_TMR_LAST = c_FETCH_TMR_W'(TIMEOUT_CYCLES - 1);

    fetch_state_t              r_state;
    logic                      r_req;
    logic [31:0]               r_addr;
    logic [31:0]               r_instr;
    logic                      r_misaligned;
    logic                      r_bus_err;
    logic [c_FETCH_TMR_W-1:0]  r_timer;
    logic                      r_flush_pending;
    logic                      w_flushing;

    assign w_flushing = r_flush_pending | i_FLUSH;

    always_ff @(posedge i_CLK) begin
        if (!i_RSTn) begin
            r_state         <= S_IDLE;
            r_req           <= 1'b0;
            r_addr          <= 32'd0;
            r_instr         <= NOP_INSTR;
            r_misaligned    <= 1'b0;
            r_bus_err       <= 1'b0;
            r_timer         <= '0;
            r_flush_pending <= 1'b0;
        end else begin
            r_misaligned <= 1'b0;
            r_bus_err    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!(i_STALL || i_FLUSH)) begin
                        r_addr <= i_PC;
                        if (i_PC[1:0] != 2'b00) begin
                            r_instr      <= NOP_INSTR;
                            r_misaligned <= 1'b1;
                            r_state      <= S_VALID;
                        end else begin
                            r_req           <= 1'b1;
                            r_timer         <= '0;
                            r_flush_pending <= 1'b0;
                            r_state         <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // A flush never aborts the bus cycle; it only marks the result for discard.
                    if (i_FLUSH) begin
                        r_flush_pending <= 1'b1;
                    end
                    if (i_INSTR_ACK) begin
                        r_req <= 1'b0;
                        if (w_flushing) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_instr <= i_INSTR_DATA;
                            r_state <= S_VALID;
                        end
                    end else if (r_timer == c_TMR_LAST) begin
                        r_req     <= 1'b0;
                        r_bus_err <= 1'b1;
                        if (w_flushing) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_instr <= NOP_INSTR;
                            r_state <= S_VALID;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_VALID: begin
                    if (i_FLUSH || !i_STALL) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_INSTR_REQ   = r_req;
    assign o_INSTR_ADDR  = r_addr;
    assign o_INSTRUCTION = r_instr;
    assign o_MISALIGNED  = r_misaligned;
    assign o_BUS_ERR     = r_bus_err;
    assign o_BUSY        = (r_state != S_IDLE);
    assign o_EN          = (r_state == S_VALID) & ~i_STALL & ~i_FLUSH;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// +----------------------------------------------------------------------+
// | tb_fetch_unit                                                        |
// | Directed self-checking bench for fetch_unit (TIMEOUT_CYCLES=4).      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_fetch_unit;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic        i_CLK;
    logic        i_RSTn;
    logic [31:0] i_PC;
    logic        i_STALL;
    logic        i_FLUSH;
    logic        o_INSTR_REQ;
    logic [31:0] o_INSTR_ADDR;
    logic        i_INSTR_ACK;
    logic [31:0] i_INSTR_DATA;
    logic [31:0] o_INSTRUCTION;
    logic        o_EN;
    logic        o_MISALIGNED;
    logic        o_BUS_ERR;
    logic        o_BUSY;

    int checks = 0;
    int errors = 0;

    fetch_unit #(
        .NOP_INSTR      (c_NOP),
        .TIMEOUT_CYCLES (4)
    ) u_dut (
        .i_CLK         (i_CLK),
        .i_RSTn        (i_RSTn),
        .i_PC          (i_PC),
        .i_STALL       (i_STALL),
        .i_FLUSH       (i_FLUSH),
        .o_INSTR_REQ   (o_INSTR_REQ),
        .o_INSTR_ADDR  (o_INSTR_ADDR),
        .i_INSTR_ACK   (i_INSTR_ACK),
        .i_INSTR_DATA  (i_INSTR_DATA),
        .o_INSTRUCTION (o_INSTRUCTION),
        .o_EN          (o_EN),
        .o_MISALIGNED  (o_MISALIGNED),
        .o_BUS_ERR     (o_BUS_ERR),
        .o_BUSY        (o_BUSY)
    );

    initial i_CLK = 1'b0;
    always #5 i_CLK = ~i_CLK;

    // Advance to just after the next rising edge; inputs are then set and
    // the caller waits #1 more before sampling.
    task automatic step();
        @(posedge i_CLK);
        #1;
    endtask

    task automatic test_reset();
        i_RSTn = 1'b0; i_STALL = 1'b1; i_FLUSH = 1'b0;
        i_PC = 32'd0; i_INSTR_ACK = 1'b0; i_INSTR_DATA = 32'd0;
        step(); step(); #1;
        checks++; if (o_INSTR_REQ !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", o_INSTR_REQ); end
        checks++; if (o_INSTR_ADDR !== 32'd0) begin errors++; $display("FAIL rst_addr got %h exp 0", o_INSTR_ADDR); end
        checks++; if (o_INSTRUCTION !== c_NOP) begin errors++; $display("FAIL rst_instr got %h exp %h", o_INSTRUCTION, c_NOP); end
        checks++; if ({o_EN, o_MISALIGNED, o_BUS_ERR, o_BUSY} !== 4'b0000) begin errors++; $display("FAIL rst_flags got %b exp 0000", {o_EN, o_MISALIGNED, o_BUS_ERR, o_BUSY}); end
        i_RSTn = 1'b1;
        step();
    endtask

    task automatic test_basic();
        i_PC = 32'h0; i_STALL = 1'b0; #1;
        checks++; if (o_BUSY !== 1'b0) begin errors++; $display("FAIL basic_idle got %b exp 0", o_BUSY); end
        step();
        i_INSTR_ACK = 1'b1; i_INSTR_DATA = 32'h0050_0093; #1;
        checks++; if (o_INSTR_REQ !== 1'b1 || o_INSTR_ADDR !== 32'h0) begin errors++; $display("FAIL basic_req got %b/%h exp 1/00000000", o_INSTR_REQ, o_INSTR_ADDR); end
        checks++; if (o_EN !== 1'b0) begin errors++; $display("FAIL basic_en_wait got %b exp 0", o_EN); end
        step();
        i_INSTR_ACK = 1'b0; #1;
        checks++; if (o_EN !== 1'b1 || o_INSTRUCTION !== 32'h0050_0093) begin errors++; $display("FAIL basic_valid got %b/%h exp 1/00500093", o_EN, o_INSTRUCTION); end
        checks++; if (o_INSTR_REQ !== 1'b0) begin errors++; $display("FAIL basic_req_drop got %b exp 0", o_INSTR_REQ); end
        i_PC = 32'h4;
        step(); #1;
        checks++; if (o_EN !== 1'b0 || o_BUSY !== 1'b0) begin errors++; $display("FAIL basic_back_idle got %b/%b exp 0/0", o_EN, o_BUSY); end
        step();
        i_INSTR_ACK = 1'b1; i_INSTR_DATA = 32'h0010_0113; #1;
        checks++; if (o_INSTR_REQ !== 1'b1 || o_INSTR_ADDR !== 32'h4) begin errors++; $display("FAIL basic_next_req got %b/%h exp 1/00000004", o_INSTR_REQ, o_INSTR_ADDR); end
        step();
        i_INSTR_ACK = 1'b0; #1;
        checks++; if (o_EN !== 1'b1 || o_INSTRUCTION !== 32'h0010_0113) begin errors++; $display("FAIL basic_next_valid got %b/%h exp 1/00100113", o_EN, o_INSTRUCTION); end
        step();
        i_STALL = 1'b1;
    endtask

    // Ack on the 4th WAIT cycle, which is also the last cycle before timeout.
    task automatic test_wait_delay();
        i_PC = 32'h8; i_STALL = 1'b0;
        step();
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (o_INSTR_REQ !== 1'b1 || o_INSTR_ADDR !== 32'h8 || o_EN !== 1'b0) begin errors++; $display("FAIL delay_wait%0d got %b/%h/%b exp 1/00000008/0", k, o_INSTR_REQ, o_INSTR_ADDR, o_EN); end
            step();
        end
        i_INSTR_ACK = 1'b1; i_INSTR_DATA = 32'h1234_5678; #1;
        checks++; if (o_INSTR_REQ !== 1'b1 || o_INSTR_ADDR !== 32'h8) begin errors++; $display("FAIL delay_wait3 got %b/%h exp 1/00000008", o_INSTR_REQ, o_INSTR_ADDR); end
        step();
        i_INSTR_ACK = 1'b0; #1;
        checks++; if (o_EN !== 1'b1 || o_INSTRUCTION !== 32'h1234_5678) begin errors++; $display("FAIL delay_valid got %b/%h exp 1/12345678", o_EN, o_INSTRUCTION); end
        checks++; if (o_BUS_ERR !== 1'b0 || o_INSTR_REQ !== 1'b0) begin errors++; $display("FAIL delay_no_err got %b/%b exp 0/0", o_BUS_ERR, o_INSTR_REQ); end
        step();
        i_STALL = 1'b1; #1;
        checks++; if (o_EN !== 1'b0 || o_BUSY !== 1'b0) begin errors++; $display("FAIL delay_once got %b/%b exp 0/0", o_EN, o_BUSY); end
    endtask

    task automatic test_misaligned();
        i_PC = 32'h102; i_STALL = 1'b0;
        step(); #1;
        checks++; if (o_INSTR_REQ !== 1'b0 || o_MISALIGNED !== 1'b1) begin errors++; $display("FAIL mis_pulse got %b/%b exp 0/1", o_INSTR_REQ, o_MISALIGNED); end
        checks++; if (o_EN !== 1'b1 || o_INSTRUCTION !== c_NOP || o_INSTR_ADDR !== 32'h102) begin errors++; $display("FAIL mis_nop got %b/%h/%h exp 1/%h/00000102", o_EN, o_INSTRUCTION, o_INSTR_ADDR, c_NOP); end
        step();
        i_STALL = 1'b1; #1;
        checks++; if (o_MISALIGNED !== 1'b0 || o_BUSY !== 1'b0 || o_INSTR_REQ !== 1'b0) begin errors++; $display("FAIL mis_end got %b/%b/%b exp 0/0/0", o_MISALIGNED, o_BUSY, o_INSTR_REQ); end
    endtask

    task automatic test_timeout();
        i_PC = 32'h20; i_STALL = 1'b0;
        step();
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (o_INSTR_REQ !== 1'b1 || o_BUS_ERR !== 1'b0) begin errors++; $display("FAIL tmo_wait%0d got %b/%b exp 1/0", k, o_INSTR_REQ, o_BUS_ERR); end
            step();
        end
        #1;
        checks++; if (o_INSTR_REQ !== 1'b0 || o_BUS_ERR !== 1'b1) begin errors++; $display("FAIL tmo_err got %b/%b exp 0/1", o_INSTR_REQ, o_BUS_ERR); end
        checks++; if (o_EN !== 1'b1 || o_INSTRUCTION !== c_NOP) begin errors++; $display("FAIL tmo_nop got %b/%h exp 1/%h", o_EN, o_INSTRUCTION, c_NOP); end
        step();
        i_STALL = 1'b1; #1;
        checks++; if (o_BUS_ERR !== 1'b0 || o_BUSY !== 1'b0) begin errors++; $display("FAIL tmo_once got %b/%b exp 0/0", o_BUS_ERR, o_BUSY); end
    endtask

    task automatic test_flush();
        i_PC = 32'h40; i_STALL = 1'b0;
        step();
        i_FLUSH = 1'b1;
        step();
        i_FLUSH = 1'b0; #1;
        checks++; if (o_INSTR_REQ !== 1'b1 || o_INSTR_ADDR !== 32'h40) begin errors++; $display("FAIL flush_req_kept got %b/%h exp 1/00000040", o_INSTR_REQ, o_INSTR_ADDR); end
        step();
        i_INSTR_ACK = 1'b1; i_INSTR_DATA = 32'hDEAD_BEEF;
        step();
        i_INSTR_ACK = 1'b0; i_PC = 32'h100; #1;
        checks++; if (o_EN !== 1'b0 || o_BUSY !== 1'b0 || o_INSTR_REQ !== 1'b0) begin errors++; $display("FAIL flush_discard got %b/%b/%b exp 0/0/0", o_EN, o_BUSY, o_INSTR_REQ); end
        checks++; if (o_INSTRUCTION !== c_NOP) begin errors++; $display("FAIL flush_instr got %h exp %h", o_INSTRUCTION, c_NOP); end
        step();
        i_INSTR_ACK = 1'b1; i_INSTR_DATA = 32'h0000_0073; #1;
        checks++; if (o_INSTR_REQ !== 1'b1 || o_INSTR_ADDR !== 32'h100) begin errors++; $display("FAIL flush_newpc got %b/%h exp 1/00000100", o_INSTR_REQ, o_INSTR_ADDR); end
        step();
        i_INSTR_ACK = 1'b0; #1;
        checks++; if (o_EN !== 1'b1 || o_INSTRUCTION !== 32'h0000_0073) begin errors++; $display("FAIL flush_handler got %b/%h exp 1/00000073", o_EN, o_INSTRUCTION); end
        step();
        i_STALL = 1'b1;
    endtask

    task automatic test_stall();
        i_PC = 32'h200; i_STALL = 1'b0;
        step();
        i_INSTR_ACK = 1'b1; i_INSTR_DATA = 32'h00A0_0113;
        step();
        i_INSTR_ACK = 1'b0; i_STALL = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (o_EN !== 1'b0 || o_INSTRUCTION !== 32'h00A0_0113 || o_BUSY !== 1'b1) begin errors++; $display("FAIL stall_hold%0d got %b/%h/%b exp 0/00a00113/1", k, o_EN, o_INSTRUCTION, o_BUSY); end
            step();
        end
        i_STALL = 1'b0; #1;
        checks++; if (o_EN !== 1'b1 || o_INSTRUCTION !== 32'h00A0_0113) begin errors++; $display("FAIL stall_release got %b/%h exp 1/00a00113", o_EN, o_INSTRUCTION); end
        step();
        i_STALL = 1'b1; #1;
        checks++; if (o_BUSY !== 1'b0) begin errors++; $display("FAIL stall_done got %b exp 0", o_BUSY); end
    endtask

    task automatic test_flush_valid();
        i_PC = 32'h300; i_STALL = 1'b0;
        step();
        i_INSTR_ACK = 1'b1; i_INSTR_DATA = 32'h0030_0193;
        step();
        i_INSTR_ACK = 1'b0; i_FLUSH = 1'b1; #1;
        checks++; if (o_EN !== 1'b0 || o_BUSY !== 1'b1) begin errors++; $display("FAIL fv_en got %b/%b exp 0/1", o_EN, o_BUSY); end
        step();
        i_FLUSH = 1'b0; i_STALL = 1'b1; #1;
        checks++; if (o_BUSY !== 1'b0 || o_EN !== 1'b0) begin errors++; $display("FAIL fv_idle got %b/%b exp 0/0", o_BUSY, o_EN); end
    endtask

    task automatic test_reset_mid();
        i_PC = 32'h400; i_STALL = 1'b0;
        step(); #1;
        checks++; if (o_INSTR_REQ !== 1'b1) begin errors++; $display("FAIL rmid_req got %b exp 1", o_INSTR_REQ); end
        i_RSTn = 1'b0;
        step();
        i_RSTn = 1'b1; i_STALL = 1'b1; i_INSTR_ACK = 1'b1; i_INSTR_DATA = 32'hCAFE_F00D; #1;
        checks++; if (o_INSTR_REQ !== 1'b0 || o_INSTR_ADDR !== 32'd0 || o_INSTRUCTION !== c_NOP) begin errors++; $display("FAIL rmid_outs got %b/%h/%h exp 0/00000000/%h", o_INSTR_REQ, o_INSTR_ADDR, o_INSTRUCTION, c_NOP); end
        checks++; if ({o_EN, o_MISALIGNED, o_BUS_ERR, o_BUSY} !== 4'b0000) begin errors++; $display("FAIL rmid_flags got %b exp 0000", {o_EN, o_MISALIGNED, o_BUS_ERR, o_BUSY}); end
        step();
        i_INSTR_ACK = 1'b0; #1;
        checks++; if (o_BUSY !== 1'b0 || o_INSTRUCTION !== c_NOP) begin errors++; $display("FAIL rmid_late_ack got %b/%h exp 0/%h", o_BUSY, o_INSTRUCTION, c_NOP); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait_delay();
        test_misaligned();
        test_timeout();
        test_flush();
        test_stall();
        test_flush_valid();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the multicycle core. It takes the program counter owned by the decode stage and issues one word read per instruction on the instruction-memory request/acknowledge bus. It presents the fetched word to decode with a one-cycle enable pulse, then waits for the updated PC before fetching again. It also handles stall and flush (interrupt redirect), misaligned PCs and bus timeouts, so decode always receives a well-formed instruction.

## Interface
Parameters:
- NOP_INSTR, 32'h0000_0013, word delivered on misalign, timeout and reset (addi x0,x0,0)
- TIMEOUT_CYCLES, 255, WAIT cycles without ack before bus error; range 2..255

Ports (clock and reset first):
- i_CLK  in  1  clock, rising edge
- i_RSTn  in  1  reset, synchronous, active-low
- i_PC  in  32  current PC from decode
- i_STALL  in  1  downstream busy; blocks new fetch start and o_EN
- i_FLUSH  in  1  redirect (IRQ taken); discard in-flight or held instruction
- o_INSTR_REQ  out  1  memory read request, registered
- o_INSTR_ADDR  out  32  word address, registered, stable while o_INSTR_REQ=1
- i_INSTR_ACK  in  1  memory ack; data valid in the same cycle
- i_INSTR_DATA  in  32  read data
- o_INSTRUCTION  out  32  instruction to decode, registered
- o_EN  out  1  decode enable, combinational, one-cycle pulse
- o_MISALIGNED  out  1  one-cycle pulse, PC[1:0]!=0
- o_BUS_ERR  out  1  one-cycle pulse, fetch timeout
- o_BUSY  out  1  state!=S_IDLE

## Operation
- States: S_IDLE, S_WAIT, S_VALID (2-bit encoding).
- S_IDLE:
  - If i_STALL|i_FLUSH, stay.
  - Else latch o_INSTR_ADDR<=i_PC.
  - If i_PC[1:0]!=0: o_INSTRUCTION<=NOP_INSTR, pulse o_MISALIGNED, go S_VALID; no bus request is issued.
  - Otherwise: o_INSTR_REQ<=1, clear timer and flush_pending, go S_WAIT.
- S_WAIT: o_INSTR_REQ stays high with o_INSTR_ADDR frozen. i_FLUSH sets flush_pending; an issued request is never aborted.
  - Ack sampled high: o_INSTR_REQ<=0. If flush_pending (or i_FLUSH this cycle), discard and go S_IDLE. Else o_INSTRUCTION<=i_INSTR_DATA, go S_VALID.
  - No ack and timer==TIMEOUT_CYCLES-1: o_INSTR_REQ<=0, pulse o_BUS_ERR. Then go S_IDLE if flushing, else load NOP_INSTR and go S_VALID.
  - Otherwise increment the timer (8-bit, never wraps because of the parameter range).
- S_VALID:
  - o_EN = (state==S_VALID) & ~i_STALL & ~i_FLUSH. When o_EN=1, go S_IDLE.
  - i_FLUSH goes to S_IDLE with o_EN=0. i_STALL holds state and o_INSTRUCTION.
- Priority: reset > i_FLUSH > i_STALL > normal.
- i_INSTR_ACK outside S_WAIT is ignored. Memory must not ack after o_INSTR_REQ falls.

## Timing
- Reset values: state S_IDLE, o_INSTR_REQ=0, o_INSTR_ADDR=0, o_INSTRUCTION=NOP_INSTR, o_EN=0, o_MISALIGNED=0, o_BUS_ERR=0, o_BUSY=0, timer=0, flush_pending=0.
- Reset mid-fetch: request drops at the same edge. The late ack is memory's responsibility and is ignored in S_IDLE.
- Minimum throughput, zero-wait memory (ack in the first WAIT cycle): cycle N S_IDLE, N+1 S_WAIT+ack, N+2 S_VALID with o_EN=1. Decode updates its PC at the end of N+2, and S_IDLE samples the new i_PC at N+3. This gives 3 cycles per instruction.
- Each extra memory wait cycle adds 1 cycle. A misaligned PC costs 2 cycles.
- Timeout: with no ack, o_BUS_ERR pulses TIMEOUT_CYCLES cycles after entry to S_WAIT.
- o_MISALIGNED and o_BUS_ERR are registered, asserted in the cycle after the detecting edge, for exactly one cycle.
- o_EN is combinational from state and i_STALL/i_FLUSH. No other output depends combinationally on inputs.

## Structure
- Shared Core.vh gains:
  - NOP_INSTR value
  - fetch state localparams (S_IDLE=2'd0, S_WAIT=2'd1, S_VALID=2'd2)
  - timer width FETCH_TMR_W=8
- Single module, no sub-module: the FSM, timer and output registers are small enough to keep in one file, around 150–200 lines.
- The core top connects:
  - decode o_PC to i_PC
  - fetch o_EN to decode i_EN
  - fetch o_INSTRUCTION to decode i_INSTRUCTION
  - IRQ-taken to i_FLUSH

## Test plan
- Reset, then i_PC=0x0, mem acks in the first WAIT cycle with 0x00500093 → o_INSTR_ADDR=0x0, o_EN high exactly 2 cycles after leaving S_IDLE, o_INSTRUCTION=0x00500093; the next request addresses 0x4 after decode advances.
- Ack delayed 3 cycles → o_INSTR_REQ high 4 cycles with address stable; o_EN pulses once with the acked data.
- i_PC=0x102 → no o_INSTR_REQ; o_MISALIGNED pulses 1 cycle; o_EN delivers 0x00000013.
- TIMEOUT_CYCLES=4, no ack → o_INSTR_REQ falls after 4 WAIT cycles; o_BUS_ERR pulses once; NOP delivered.
- i_FLUSH one cycle mid-WAIT, ack 2 cycles later with 0xDEADBEEF → no o_EN, return to S_IDLE, the next fetch uses the new i_PC (handler base 0x100).
- S_VALID with i_STALL high 5 cycles → o_EN low throughout, o_INSTRUCTION held; o_EN pulses on the first unstalled cycle. Reset asserted in S_WAIT → o_INSTR_REQ=0 and all outputs at reset values next cycle.
